rca_arbiter: RTL and testbench

RCA_ARBITER -- requirements
Module: rca_arbiter

---
 rtl/rca_arbiter_pkg.sv | 27 ++
 rtl/ripple_carry.sv | 28 ++
 rtl/rca_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rca_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_arbiter_pkg.sv
// Shared types for the two-requester ripple-carry adder arbiter.
//   state_e  : burst FSM state (IDLE, LOCK); LOCK only exists in the
//              RCA_CHAIN_EN build.
//   req_id_t : index of a requester (0 or 1).
//   rr_pick  : round-robin pick between two requesters.
package rca_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // With both requesters valid the favoured one wins; with only one valid
  // that one wins. With none valid the result is unused (REQ0).
  function automatic req_id_t rr_pick(input logic v0, input logic v1,
                                      input req_id_t prio);
    if (v0 && v1) return prio;
    else if (v1)  return REQ1;
    else          return REQ0;
  endfunction

endpackage

// File: rtl/ripple_carry.sv
// Plain SIZE-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   a_i, b_i : operands (SIZE bits)
//   cin_i    : carry into bit 0
//   sum_o    : (a + b + cin) mod 2^SIZE
//   cout_o   : carry out of bit SIZE-1
module ripple_carry #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic            cin_i,
  output logic [SIZE-1:0] sum_o,
  output logic            cout_o
);

  logic [SIZE:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[SIZE];

endmodule

// File: rtl/rca_arbiter.sv
// Two requesters share one ripple-carry adder through a round-robin
// arbiter; the sum lands in a single result register one edge after the
// beat is accepted.
//
// Handshake: a beat transfers on a rising edge where reqN_valid and
// reqN_ready are both 1; a result transfers where rsp_valid and rsp_ready
// are both 1. Valid never depends on ready; ready may depend on valid.
//
// Build option: define RCA_CHAIN_EN for multi-word bursts. A beat with
// last=0 locks the arbiter to its requester (IDLE -> LOCK) and the adder
// carry is stored and used as carry-in for that requester's next beat.
// Without the macro every beat is final and reqN_last is ignored.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready            requester N handshake (N = 0,1)
//   reqN_a, reqN_b, reqN_cin    operands and carry-in
//   reqN_last                   final beat of a burst
//   rsp_valid/ready             result handshake
//   rsp_id, rsp_sum, rsp_cout   owner, sum and carry-out of the result
//   dbg_state_o, dbg_prio_o     FSM state and favoured requester
//   dbg_last_o                  last flag of the currently granted beat
module rca_arbiter
  import rca_arbiter_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic            req0_cin,
  input  logic            req0_last,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  input  logic            req1_cin,
  input  logic            req1_last,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_sum,
  output logic            rsp_cout,
  output state_e          dbg_state_o,
  output logic            dbg_prio_o,
  output logic            dbg_last_o
);

  req_id_t         prio_q, prio_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [SIZE-1:0] rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  req_id_t         rsp_id_q, rsp_id_d;

  req_id_t         winner;
  logic            gnt_any;
  logic            slot_free;
  logic            accept;
  logic [SIZE-1:0] add_a, add_b, add_sum;
  logic            sel_cin, sel_last, add_cin, add_cout;

`ifdef RCA_CHAIN_EN
  state_e  state_q, state_d;
  req_id_t lock_id_q, lock_id_d;
  logic    carry_q, carry_d;
`endif

  // Grant: round-robin in IDLE; in LOCK only the locked requester may go.
  always_comb begin
    winner  = rr_pick(req0_valid, req1_valid, prio_q);
    gnt_any = req0_valid | req1_valid;
`ifdef RCA_CHAIN_EN
    if (state_q == LOCK) begin
      winner  = lock_id_q;
      gnt_any = (lock_id_q == REQ1) ? req1_valid : req0_valid;
    end
`endif
  end

  // The slot is free when empty or being drained this cycle.
  assign slot_free  = !rsp_valid_q || rsp_ready;
  assign accept     = gnt_any && slot_free;
  assign req0_ready = accept && (winner == REQ0);
  assign req1_ready = accept && (winner == REQ1);

  assign add_a    = (winner == REQ1) ? req1_a    : req0_a;
  assign add_b    = (winner == REQ1) ? req1_b    : req0_b;
  assign sel_cin  = (winner == REQ1) ? req1_cin  : req0_cin;
  assign sel_last = (winner == REQ1) ? req1_last : req0_last;

`ifdef RCA_CHAIN_EN
  // Continuation beats take the carry left by the previous word.
  assign add_cin = (state_q == LOCK) ? carry_q : sel_cin;
`else
  assign add_cin = sel_cin;
`endif

  ripple_carry #(
    .SIZE (SIZE)
  ) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    prio_d      = prio_q;
`ifdef RCA_CHAIN_EN
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    carry_d     = carry_q;
`endif
    if (accept) begin
      // A drain in the same cycle is simply overwritten: no bubble.
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_id_d    = winner;
`ifdef RCA_CHAIN_EN
      if (sel_last) begin
        state_d = IDLE;
        prio_d  = req_id_t'(~winner);
      end else begin
        // Mid-burst: hold the requester and keep prio where it was.
        state_d   = LOCK;
        lock_id_d = winner;
        carry_d   = add_cout;
      end
`else
      prio_d = req_id_t'(~winner);
`endif
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= REQ0;
      prio_q      <= REQ0;
`ifdef RCA_CHAIN_EN
      state_q     <= IDLE;
      lock_id_q   <= REQ0;
      carry_q     <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      prio_q      <= prio_d;
`ifdef RCA_CHAIN_EN
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      carry_q     <= carry_d;
`endif
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_id     = rsp_id_q;
  assign dbg_prio_o = prio_q;
  assign dbg_last_o = sel_last;
`ifdef RCA_CHAIN_EN
  assign dbg_state_o = state_q;
`else
  assign dbg_state_o = IDLE;
`endif

endmodule

// File: tb/tb_rca_arbiter.sv
// Bench for rca_arbiter (SIZE=8). Accepted beats push their hand-computed
// {id, cout, sum} into exp_q; a monitor pops and compares on every result
// handshake. Directed checks cover reset, latency, stall and reset cases.
// The burst section runs only when RCA_CHAIN_EN is defined.
module tb_rca_arbiter;
  import rca_arbiter_pkg::*;

  localparam int SIZE = 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req0_valid, req0_ready, req0_cin, req0_last;
  logic [SIZE-1:0] req0_a, req0_b;
  logic            req1_valid, req1_ready, req1_cin, req1_last;
  logic [SIZE-1:0] req1_a, req1_b;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [SIZE-1:0] rsp_sum;
  state_e          dbg_state;
  logic            dbg_prio, dbg_last;

  rca_arbiter #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_cin    (req0_cin),
    .req0_last   (req0_last),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_cin    (req1_cin),
    .req1_last   (req1_last),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout),
    .dbg_state_o (dbg_state),
    .dbg_prio_o  (dbg_prio),
    .dbg_last_o  (dbg_last)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [SIZE+1:0] exp_q[$];
  logic [SIZE:0]   exp0, exp1;   // {cout, sum} for the beat on each port
  logic [SIZE+1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Accept watcher: record the expected result of every accepted beat.
  always @(negedge clk) begin
    if (rst_n) begin
      check("one_grant", 32'(req0_ready & req1_ready), 0);
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, exp0});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, exp1});
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", 32'({rsp_id, rsp_cout, rsp_sum}), 32'(mon_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic port, input logic [SIZE-1:0] a, b,
                      input logic cin, last, input logic [SIZE:0] exp);
    logic done = 1'b0;
    if (port) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_last = last;
      exp1 = exp; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_last = last;
      exp0 = exp; req0_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = port ? req1_ready : req0_ready;
    end
    check("send_accepted", 32'(done), 1);
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_both();
    req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0; req0_last = 1'b1;
    exp0 = 9'h003;
    req1_a = 8'h10; req1_b = 8'h20; req1_cin = 1'b1; req1_last = 1'b1;
    exp1 = 9'h031;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0; req0_last = 1;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0; req1_last = 1;
    rsp_ready = 0; exp0 = 0; exp1 = 0;

    // Reset state
    #12;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_sum",   32'(rsp_sum), 0);
    check("rst_cout",  32'(rsp_cout), 0);
    check("rst_id",    32'(rsp_id), 0);
    check("rst_prio",  32'(dbg_prio), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single requester, latency 1
    send(1'b0, 8'h0F, 8'h01, 1'b0, 1'b1, 9'h010);
    check("lat_valid", 32'(rsp_valid), 1);
    check("lat_sum",   32'(rsp_sum), 32'h10);
    check("lat_cout",  32'(rsp_cout), 0);
    check("lat_id",    32'(rsp_id), 0);

    // Wrap-around cases
    do_reset();
    send(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF);
    check("wrap_sum",  32'(rsp_sum), 32'hFF);
    check("wrap_cout", 32'(rsp_cout), 1);
    send(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 9'h100);
    send(1'b1, 8'h7F, 8'h00, 1'b1, 1'b1, 9'h080);

    // Round-robin with both valid
    do_reset();
    set_both();
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("rr_order", 32'(req1_ready), 32'(got % 2));
        got++;
      end
    end
    check("rr_count", 32'(got), 4);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Back-pressure: result frozen, readies low, then no bubble
    do_reset();
    rsp_ready = 1'b0;
    set_both();
    @(negedge clk);
    check("stall_first_rdy", 32'(req0_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_sum",   32'(rsp_sum), 32'h03);
      check("stall_id",    32'(rsp_id), 0);
      check("stall_rdy",   32'({req0_ready, req1_ready}), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("resume_rdy1", 32'(req1_ready), 1);
    @(negedge clk);
    check("nobubble_valid", 32'(rsp_valid), 1);
    check("nobubble_id",    32'(rsp_id), 1);
    check("nobubble_sum",   32'(rsp_sum), 32'h31);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Reset with a pending result
    do_reset();
    rsp_ready = 1'b0;
    send(1'b0, 8'h0F, 8'h01, 1'b0, 1'b1, 9'h010);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 32'(rsp_valid), 0);
    check("async_rst_sum",   32'(rsp_sum), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_prio",  32'(dbg_prio), 0);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));
    rsp_ready = 1'b1;
    set_both();
    @(negedge clk);
    check("post_rst_grant", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

`ifdef RCA_CHAIN_EN
    // Two-word burst from req1 while req0 waits
    do_reset();
    rsp_ready = 1'b1;
    send(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 9'h101);
    check("chain_lock_state", 32'(dbg_state), 32'(LOCK));
    check("chain_lock_prio",  32'(dbg_prio), 0);
    req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0; req0_last = 1'b1;
    exp0 = 9'h003;
    req0_valid = 1'b1;
    @(negedge clk);
    check("chain_r0_blocked", 32'(req0_ready), 0);
    @(posedge clk); #1;
    send(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 9'h001);
    check("chain_idle", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    check("chain_next_grant", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while locked with a pending result
    rsp_ready = 1'b0;
    send(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
    check("chain_lock2", 32'(dbg_state), 32'(LOCK));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("chain_rst_valid", 32'(rsp_valid), 0);
    check("chain_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    check("chain_rst_prio", 32'(dbg_prio), 0);
`endif

    // Drain outstanding results
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
